// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Brief    : Registered immediate-extension stage with valid/ready handshake
//            and a 1-entry skid buffer between decode and execute.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam int c_E = OUT_W - IN_W;

    localparam logic [1:0] c_MODE_SIGN   = 2'b00;
    localparam logic [1:0] c_MODE_ZERO   = 2'b01;
    localparam logic [1:0] c_MODE_UPPER  = 2'b10;
    localparam logic [1:0] c_MODE_BRANCH = 2'b11;

    logic             r_outValid;
    logic [OUT_W-1:0] r_outData;
    logic             r_skidValid;
    logic [OUT_W-1:0] r_skidData;

    logic [OUT_W-1:0] w_signExt;
    logic [OUT_W-1:0] w_extData;
    logic             w_push;
    logic             w_pop;

    assign w_signExt = {{c_E{in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        w_extData = w_signExt;
        case (in_mode)
            c_MODE_SIGN:   w_extData = w_signExt;
            c_MODE_ZERO:   w_extData = {{c_E{1'b0}}, in_imm};
            c_MODE_UPPER:  w_extData = {in_imm, {c_E{1'b0}}};
            c_MODE_BRANCH: w_extData = w_signExt << BR_SHIFT;
            default:       w_extData = w_signExt;
        endcase
    end

    // in_ready comes straight from the skid flag so there is no in->out comb path.
    assign w_push = in_valid & ~r_skidValid;
    assign w_pop  = r_outValid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
        end else if (flush) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (!r_outValid || w_pop) begin
            if (r_skidValid) begin
                r_outValid  <= 1'b1;
                r_outData   <= r_skidData;
                r_skidValid <= w_push;
                if (w_push) begin
                    r_skidData <= w_extData;
                end
            end else if (w_push) begin
                r_outValid <= 1'b1;
                r_outData  <= w_extData;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (w_push) begin
            r_skidValid <= 1'b1;
            r_skidData  <= w_extData;
        end
    end

    assign in_ready  = ~r_skidValid;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign occupancy = {1'b0, r_outValid} + {1'b0, r_skidValid};

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Brief    : Scoreboard bench for imm_extend_pipe (default and 12/24/1 params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [15:0] inImm;
    logic [1:0]  inMode;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [1:0]  occupancy;

    logic        p6InValid;
    logic        p6InReady;
    logic [11:0] p6InImm;
    logic [1:0]  p6InMode;
    logic        p6OutValid;
    logic        p6OutReady;
    logic [23:0] p6OutData;
    logic [1:0]  p6Occupancy;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] sbQ[$];
    logic        prevHold = 1'b0;
    logic [31:0] prevData = '0;

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_imm    (inImm),
        .in_mode   (inMode),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .occupancy (occupancy)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(24), .BR_SHIFT(1)) dutP6 (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .in_valid  (p6InValid),
        .in_ready  (p6InReady),
        .in_imm    (p6InImm),
        .in_mode   (p6InMode),
        .out_valid (p6OutValid),
        .out_ready (p6OutReady),
        .out_data  (p6OutData),
        .occupancy (p6Occupancy)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refExt(input logic [15:0] imm, input logic [1:0] mode);
        logic signed [31:0] s;
        s = 32'(signed'(imm));
        case (mode)
            2'd0:    return s;
            2'd1:    return {16'h0000, imm};
            2'd2:    return {imm, 16'h0000};
            default: return s * 4;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1ns after the rising edge, so the falling edge sees what the next edge will.
    always @(negedge clk) begin
        if (rst) begin
            sbQ.delete();
            prevHold = 1'b0;
        end else begin
            if (prevHold) begin
                checkVal("hold_valid", outValid, 1'b1);
                checkVal("hold_data", outData, prevData);
            end
            if (outValid && outReady) begin
                if (sbQ.size() == 0) begin
                    checkVal("sb_unexpected", outData, 32'hDEADBEEF);
                end else begin
                    checkVal("sb_data", outData, sbQ.pop_front());
                end
            end
            if (flush) begin
                sbQ.delete();
            end else if (inValid && inReady) begin
                sbQ.push_back(refExt(inImm, inMode));
            end
            prevHold = outValid && !outReady && !flush;
            prevData = outData;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inImm = '0; inMode = '0; outReady = 1'b0;
        p6InValid = 1'b0; p6InImm = '0; p6InMode = '0; p6OutReady = 1'b1;
        step(); step();
        checkVal("rst_valid", outValid, 1'b0);
        checkVal("rst_occ", occupancy, 2'd0);
        checkVal("rst_ready", inReady, 1'b1);
        checkVal("rst_data", outData, 32'h0);
        rst = 1'b0;
        step();

        // T1 sign extension, 1-cycle latency
        inValid = 1'b1; inImm = 16'h8001; inMode = 2'b00; outReady = 1'b1;
        step();
        inValid = 1'b0;
        checkVal("t1_valid", outValid, 1'b1);
        checkVal("t1_data", outData, 32'hFFFF8001);
        step();

        // T2 all modes back to back
        for (int m = 0; m < 4; m++) begin
            inValid = 1'b1; inImm = 16'hFFFE; inMode = 2'(m);
            step();
            checkVal("t2_tput", outValid, 1'b1);
            checkVal("t2_ready", inReady, 1'b1);
        end
        inValid = 1'b0;
        checkVal("t2_last", outData, 32'hFFFFFFF8);
        step();

        // T3 back-pressure fills skid
        outReady = 1'b0; inMode = 2'b01;
        inValid = 1'b1; inImm = 16'h0001; step();
        inImm = 16'h0002; step();
        inValid = 1'b0;
        checkVal("t3_occ2", occupancy, 2'd2);
        checkVal("t3_ready0", inReady, 1'b0);
        checkVal("t3_held", outData, 32'h1);
        step();
        outReady = 1'b1;
        step();
        checkVal("t3_second", outData, 32'h2);
        checkVal("t3_occ1", occupancy, 2'd1);
        checkVal("t3_ready1", inReady, 1'b1);
        step();
        checkVal("t3_occ0", occupancy, 2'd0);

        // T4 flush with two entries held and input offered
        outReady = 1'b0; inMode = 2'b00;
        inValid = 1'b1; inImm = 16'h0011; step();
        inImm = 16'h0022; step();
        flush = 1'b1; inImm = 16'h1234;
        step();
        flush = 1'b0; inValid = 1'b0;
        checkVal("t4_valid", outValid, 1'b0);
        checkVal("t4_occ", occupancy, 2'd0);
        checkVal("t4_ready", inReady, 1'b1);
        // flush while in_ready=1: offered input is still discarded
        inValid = 1'b1; inImm = 16'h0033; step();
        flush = 1'b1; inImm = 16'h0044; step();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        step(); step();
        checkVal("t4_empty", outValid, 1'b0);

        // T5 asynchronous reset between edges
        outReady = 1'b0;
        inValid = 1'b1; inImm = 16'h0055; step();
        inImm = 16'h0066; step();
        inValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkVal("t5_valid", outValid, 1'b0);
        checkVal("t5_occ", occupancy, 2'd0);
        checkVal("t5_ready", inReady, 1'b1);
        checkVal("t5_data", outData, 32'h0);
        step();
        rst = 1'b0;
        step();
        outReady = 1'b1; inValid = 1'b1; inImm = 16'h7FFF; inMode = 2'b11;
        step();
        inValid = 1'b0;
        checkVal("t5_valid_after", outValid, 1'b1);
        checkVal("t5_data_after", outData, 32'h0001FFFC);
        step();

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            inValid  = 1'($urandom_range(0, 1));
            outReady = ($urandom_range(0, 3) != 0);
            inImm    = 16'($urandom);
            inMode   = 2'($urandom_range(0, 3));
            flush    = ($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        step(); step(); step();
        checkVal("sb_empty", sbQ.size(), 32'd0);

        // T6 alternate parameters: IN_W=12, OUT_W=24, BR_SHIFT=1
        p6InValid = 1'b1; p6InImm = 12'h800; p6InMode = 2'b11;
        step();
        checkVal("t6_valid", p6OutValid, 1'b1);
        checkVal("t6_branch", p6OutData, 24'hFFF000);
        p6InMode = 2'b10;
        step();
        checkVal("t6_upper", p6OutData, 24'h800000);
        p6InMode = 2'b00;
        step();
        p6InValid = 1'b0;
        checkVal("t6_sign", p6OutData, 24'hFFF800);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
